// File: rtl/canvas_template_matcher.sv
// Scores a 1-bit canvas against NUM_TPL stored templates and returns the best match code.
// Optional build macro REJECT_THRESHOLD_EN adds a minimum-score reject code.
module canvas_template_matcher #(
   parameter int unsigned CANVAS_W   = 32,
   parameter int unsigned CANVAS_H   = 32,
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned NUM_TPL    = 16,
   parameter int unsigned SCORE_W    = 11,
   parameter logic [7:0]  CODE_BASE  = 8'd65,
   parameter logic [7:0]  BLANK_CODE = 8'd32,
   parameter int unsigned MIN_INK    = 4
`ifdef REJECT_THRESHOLD_EN
   ,
   parameter int unsigned REJECT_MIN   = (3 * CANVAS_W * CANVAS_H) / 4,
   parameter logic [7:0]  UNKNOWN_CODE = 8'd63
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               rd_en,
   output logic [ADDR_W-1:0]  rd_addr,
   input  logic               pix_data,
   input  logic [NUM_TPL-1:0] tpl_data,
   output logic               busy,
   output logic               result_valid,
   input  logic               result_ready,
   output logic [7:0]         result_code,
   output logic [SCORE_W-1:0] result_score
);

   localparam int unsigned N     = CANVAS_W * CANVAS_H;
   localparam int unsigned IDX_W = (NUM_TPL > 1) ? $clog2(NUM_TPL) : 1;
   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

   typedef enum logic [2:0] {IDLE, SCAN, DRAIN, SELECT, DONE} state_t;

   state_t             state;
   logic               vld;
   logic [SCORE_W-1:0] score [NUM_TPL];
   logic [SCORE_W-1:0] ink;
   logic [IDX_W-1:0]   sel_idx;
   logic [SCORE_W-1:0] best;
   logic [IDX_W-1:0]   best_idx;

   logic [SCORE_W-1:0] sel_score;
   logic               take;
   logic [SCORE_W-1:0] cand;
   logic [IDX_W-1:0]   cand_idx;
   logic               last_sel;
   logic [7:0]         fin_code;
   logic [SCORE_W-1:0] fin_score;

   // Running-best update for the template under comparison; index 0 seeds the best.
   always_comb begin
      sel_score = score[sel_idx];
      take      = (sel_idx == '0) || (sel_score > best);
      cand      = take ? sel_score : best;
      cand_idx  = take ? sel_idx : best_idx;
      last_sel  = (sel_idx == IDX_W'(NUM_TPL - 1));
      fin_code  = BLANK_CODE;
      fin_score = '0;
      if (ink >= SCORE_W'(MIN_INK)) begin
         fin_code  = 8'(CODE_BASE + 8'(cand_idx));
         fin_score = cand;
`ifdef REJECT_THRESHOLD_EN
         if (cand < SCORE_W'(REJECT_MIN)) fin_code = UNKNOWN_CODE;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rd_en        <= 1'b0;
         rd_addr      <= '0;
         vld          <= 1'b0;
         ink          <= '0;
         sel_idx      <= '0;
         best         <= '0;
         best_idx     <= '0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         result_code  <= '0;
         result_score <= '0;
         for (int i = 0; i < NUM_TPL; i++) score[i] <= '0;
      end else if (start) begin
         // Restart wins over everything, including a pending handshake.
         state        <= SCAN;
         rd_en        <= 1'b1;
         rd_addr      <= '0;
         vld          <= 1'b0;
         ink          <= '0;
         sel_idx      <= '0;
         busy         <= 1'b1;
         result_valid <= 1'b0;
         for (int i = 0; i < NUM_TPL; i++) score[i] <= '0;
      end else begin
         vld <= rd_en;
         if (vld) begin
            if (pix_data && ink != SCORE_MAX) ink <= ink + SCORE_W'(1);
            for (int i = 0; i < NUM_TPL; i++) begin
               if ((pix_data == tpl_data[i]) && (score[i] != SCORE_MAX))
                  score[i] <= score[i] + SCORE_W'(1);
            end
         end
         case (state)
            IDLE: ;
            SCAN: begin
               if (rd_addr == ADDR_W'(N - 1)) begin
                  rd_en <= 1'b0;
                  state <= DRAIN;
               end else begin
                  rd_addr <= rd_addr + ADDR_W'(1);
               end
            end
            DRAIN: begin
               sel_idx <= '0;
               state   <= SELECT;
            end
            SELECT: begin
               best     <= cand;
               best_idx <= cand_idx;
               if (last_sel) begin
                  state        <= DONE;
                  busy         <= 1'b0;
                  result_valid <= 1'b1;
                  result_code  <= fin_code;
                  result_score <= fin_score;
               end else begin
                  sel_idx <= sel_idx + IDX_W'(1);
               end
            end
            DONE: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_canvas_template_matcher.sv
// Scoreboard bench for canvas_template_matcher on a 4x4 canvas with 4 templates.
module tb_canvas_template_matcher;

   localparam int unsigned AW = 4;
   localparam int unsigned SW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          pix_data = 1'b0;
   logic [3:0]    tpl_data = '0;
   logic          busy;
   logic          result_valid;
   logic          result_ready = 1'b1;
   logic [7:0]    result_code;
   logic [SW-1:0] result_score;

   logic [15:0]   cmem = '0;
   logic [15:0]   tm [4];

   typedef struct packed {
      logic [7:0]    code;
      logic [SW-1:0] score;
   } exp_t;
   exp_t sb [$];

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   canvas_template_matcher #(
      .CANVAS_W(4), .CANVAS_H(4), .ADDR_W(AW), .NUM_TPL(4), .SCORE_W(SW),
      .CODE_BASE(8'd65), .BLANK_CODE(8'd32), .MIN_INK(4)
`ifdef REJECT_THRESHOLD_EN
      , .REJECT_MIN(12), .UNKNOWN_CODE(8'd63)
`endif
   ) dut (
      .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
      .pix_data(pix_data), .tpl_data(tpl_data), .busy(busy),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_code(result_code), .result_score(result_score)
   );

   // Synchronous-read framebuffer and template ROM.
   always @(posedge clk) begin
      if (rd_en) begin
         pix_data <= cmem[rd_addr];
         tpl_data <= {tm[3][rd_addr], tm[2][rd_addr], tm[1][rd_addr], tm[0][rd_addr]};
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Pops the scoreboard on every accepted result.
   always @(negedge clk) begin
      if (!rst && result_valid && result_ready && !start) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result_code", int'(result_code), int'(e.code));
            chk("result_score", int'(result_score), int'(e.score));
         end
      end
   end

   task automatic load(input logic [15:0] c, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] a2, input logic [15:0] a3);
      cmem  = c;
      tm[0] = a0;
      tm[1] = a1;
      tm[2] = a2;
      tm[3] = a3;
   endtask

   task automatic push(input logic [7:0] code, input logic [SW-1:0] score);
      exp_t e;
      e.code  = code;
      e.score = score;
      sb.push_back(e);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Called 1 time unit after the start edge; counts edges until result_valid.
   task automatic wait_result(input int exp_lat, input bit chk_addr);
      int  cnt;
      bit  pre_busy;
      cnt      = 0;
      pre_busy = 1'b0;
      if (chk_addr) chk("rd_addr_0", int'(rd_addr), 0);
      while (!result_valid && cnt < 100) begin
         @(posedge clk);
         #1;
         cnt++;
         if (chk_addr && cnt < 16) begin
            chk("rd_addr_step", int'(rd_addr), cnt);
            chk("rd_en_scan", int'(rd_en), 1);
         end
         if (cnt == exp_lat - 1) pre_busy = busy;
      end
      chk("latency", cnt, exp_lat);
      chk("busy_before_valid", int'(pre_busy), 1);
      chk("busy_at_valid", int'(busy), 0);
   endtask

   initial begin
      int n;
      logic [7:0] rej_code;
`ifdef REJECT_THRESHOLD_EN
      rej_code = 8'd63;
`else
      rej_code = 8'd65;
`endif
      load(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd_en", int'(rd_en), 0);
      chk("rst_rd_addr", int'(rd_addr), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(result_valid), 0);
      chk("rst_code", int'(result_code), 0);
      chk("rst_score", int'(result_score), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Canvas equals template 2.
      load(16'h00FF, 16'h0000, 16'hFFFF, 16'h00FF, 16'hF0F0);
      push(8'd67, SW'(16));
      pulse_start();
      wait_result(21, 1'b1);
      @(posedge clk);
      #1 chk("valid_drop", int'(result_valid), 0);

      // Blank canvas; ready held high the whole time.
      load(16'h0000, 16'hFFFF, 16'h0F0F, 16'h0000, 16'h1234);
      push(8'd32, SW'(0));
      pulse_start();
      wait_result(21, 1'b0);
      @(posedge clk);
      #1;

      // Tie between templates 1 and 3.
      load(16'h00FF, 16'h0000, 16'h00FC, 16'h0F0F, 16'h03FF);
      push(8'd66, SW'(14));
      pulse_start();
      wait_result(21, 1'b0);
      @(posedge clk);
      #1;

      // Back-pressure: result must hold while ready is low.
      result_ready = 1'b0;
      load(16'h00FF, 16'h0000, 16'hFFFF, 16'h00FF, 16'hF0F0);
      push(8'd67, SW'(16));
      pulse_start();
      wait_result(21, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", int'(result_valid), 1);
         chk("hold_code", int'(result_code), 67);
         chk("hold_score", int'(result_score), 16);
      end
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_ack_valid", int'(result_valid), 0);
      chk("post_ack_busy", int'(busy), 0);
      chk("post_ack_rd_en", int'(rd_en), 0);

      // Start beats a simultaneous ready; the pending result is dropped.
      result_ready = 1'b0;
      load(16'h00FF, 16'h0000, 16'h00FC, 16'h0F0F, 16'h03FF);
      pulse_start();
      wait_result(21, 1'b0);
      load(16'h00FF, 16'h0003, 16'hFFFF, 16'hFF00, 16'h0000);
      push(rej_code, SW'(10));
      start        = 1'b1;
      result_ready = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("restart_valid_clr", int'(result_valid), 0);
      chk("restart_busy", int'(busy), 1);
      wait_result(21, 1'b1);
      @(posedge clk);
      #1;

      // Restart in the middle of a scan.
      load(16'h00FF, 16'h0000, 16'hFFFF, 16'h00FF, 16'hF0F0);
      push(8'd67, SW'(16));
      pulse_start();
      n = 0;
      while (rd_addr != AW'(7) && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("reach_addr7", int'(rd_addr), 7);
      pulse_start();
      wait_result(21, 1'b1);
      @(posedge clk);
      #1;

      // Reset mid-scan: nothing may come out.
      pulse_start();
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_rd_en", int'(rd_en), 0);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (result_valid) n++;
      end
      chk("midrst_no_result", n, 0);

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("scoreboard_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
